squ_out_packer: RTL and testbench
=================================

# squ_out_packer

Downstream neighbour of the final squeeze accumulate/bias stage. Takes each 12-bit fixed-point squeeze result with its valid flag, applies ReLU and 12→8-bit requantisation, and packs eight results per 64-bit word into an on-block output FIFO. The host/DMA side drains that FIFO. Per-layer element counting lets the block flush a partial last word and signal end of layer.

## Interface
- Parameters:
  - FIFO_DEPTH, 64: output FIFO depth in 64-bit words. Power of two.
  - FIFO_CNT_W, 7: width of the data count, log2(FIFO_DEPTH)+1.
- Ports:
  - clk_i, input, 1: system clock. Single clock domain.
  - rst_i, input, 1: reset. Synchronous, active-high.
  - start_i, input, 1: one-cycle layer start. Clears pack state, counters and overflow.
  - no_of_squ_kernals_i, input, 10: number of squeeze kernels − 1. Sampled on start_i.
  - squ_layer_dimension_i, input, 7: layer dimension − 1. Sampled on start_i.
  - data_i, input, 12: signed result, 4 fractional bits.
  - flag_i, input, 1: data_i is valid this cycle.
  - fifo_out_clr_i, input, 1: empties the FIFO. Does not affect pack state.
  - fifo_out_rd_en_i, input, 1: pops one word.
  - fifo_out_rd_data_o, output, 64: popped word.
  - fifo_out_data_count_o, output, FIFO_CNT_W: number of words held, 0..FIFO_DEPTH.
  - fifo_out_empty_o, output, 1: count == 0.
  - layer_done_o, output, 1: one-cycle pulse after the final word of the layer is written.
  - overflow_o, output, 1: sticky. A word was dropped because the FIFO was full.

## Operation
- **Total elements per layer:** N = (no_of_squ_kernals_i+1)·(squ_layer_dimension_i+1)². Held in a 24-bit register loaded on start_i.
- **Requantise** (stage 1, registered on flag_i):
  - If data_i[11] = 1: q = 0 (ReLU).
  - Else q = {1'b0, data_i[10:4]}, range 0..127.
  - Optional rounding per Configuration.
- **Pack** (stage 2):
  - Byte lane counter 0..7. Lane k is placed at bits [8k+7:8k]; the first element goes in [7:0].
  - When lane 7 is filled, the word is written to the FIFO and the lane counter wraps to 0.
- **Element counter:**
  - Counts accepted elements.
  - On element N, the word is written regardless of lane; unfilled lanes are 0.
  - Then: lane counter = 0, element counter = 0, and layer_done_o pulses.
- **Elements beyond N:** a following flag_i, with no new start_i, begins a new layer with the same N.
- **FIFO:**
  - Registered read. fifo_out_rd_data_o is updated on the cycle after rd_en and holds its value otherwise.
  - rd_en while empty: ignored, count unchanged.
  - Write while full with no read: word dropped, overflow_o set.
  - Write while full with a simultaneous read: both happen, count stays FIFO_DEPTH, no overflow.
  - Write while empty with a simultaneous read: read ignored, count becomes 1.
- **fifo_out_clr_i:**
  - Count = 0, and read/write pointers = 0.
  - Takes priority over a same-cycle write or read; that word is lost but overflow_o is not set.
- **start_i:**
  - Any partial word is discarded and no flush occurs.
  - flag_i in the same cycle as start_i is ignored.
  - Stage-1/2 valids are cleared, so an element in flight is also discarded.

## Timing
- Values on rst_i:
  - fifo_out_rd_data_o = 0.
  - fifo_out_data_count_o = 0.
  - fifo_out_empty_o = 1.
  - layer_done_o = 0, overflow_o = 0.
  - Counters = 0 and N = 1 (configuration registers = 0).
- flag_i at cycle t → q registered at t+1 → FIFO write at t+2 (when lane 7 or element N) → count increments, visible at t+3.
- layer_done_o is high at t+3 for element N at t. It coincides with the count increment.
- Back-to-back flag_i every cycle is supported with no stall. There is no backpressure toward the upstream stage.
- fifo_out_empty_o and fifo_out_data_count_o are registered and updated in the same cycle as the pointers.

## Configuration
- Macro SQU_OUT_ROUND_EN.
  - When defined: round-half-up, q = min(data_i[10:4] + data_i[3], 127) for non-negative inputs.
  - When undefined: truncate, q = data_i[10:4].
- ReLU applies in both builds.

## Test plan
- **Full word:** K−1=0, D−1=1 (N=4). Send data 0x010,0x020,0x030,0x040 → one word 0x00000000_04030201, layer_done_o pulse, count=1.
- **ReLU and rounding:**
  - 0x818 → byte 0x00.
  - 0x7FF → byte 0x7F in both builds.
  - 0x018 → 0x02 with SQU_OUT_ROUND_EN, 0x01 without.
- **Multi-word with partial flush:** N=18 (K−1=1, D−1=2). 18 consecutive flags → 3 words. The last word has lanes 2..7 = 0. One layer_done_o pulse, at the third write.
- **FIFO boundaries:**
  - Fill 64 words.
  - A 65th write without a read → overflow_o=1, count stays 64.
  - A 65th write with a simultaneous rd_en → count 64, overflow 0.
  - rd_en on empty → count stays 0.
- **start_i mid-layer:** start_i after 3 of 8 elements → no word written. A new layer of 8 elements → word containing only the new bytes.
- **Reset/clear mid-operation:** rst_i with 5 words queued → all outputs at reset values next cycle. fifo_out_clr_i during a write → count 0, overflow_o unchanged.

Source files
------------

// File: rtl/squ_out_packer.sv
// squ_out_packer
// ReLU + 12->8 bit requantisation of squeeze results, packing of eight
// bytes per 64-bit word, per-layer element counting with partial-word flush,
// and an on-block output FIFO drained by the host/DMA side.
//
// Build option: define SQU_OUT_ROUND_EN to round half-up (saturating at 127)
// instead of truncating the four fractional bits.
//
// Pipeline: flag_i at t -> q registered at t+1 -> word presented to the FIFO
// at t+2 -> count / layer_done_o visible at t+3.

module squ_out_packer #(
    parameter int FIFO_DEPTH = 64,
    parameter int FIFO_CNT_W = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [9:0]            no_of_squ_kernals_i,
    input  logic [6:0]            squ_layer_dimension_i,
    input  logic [11:0]           data_i,
    input  logic                  flag_i,
    input  logic                  fifo_out_clr_i,
    input  logic                  fifo_out_rd_en_i,
    output logic [63:0]           fifo_out_rd_data_o,
    output logic [FIFO_CNT_W-1:0] fifo_out_data_count_o,
    output logic                  fifo_out_empty_o,
    output logic                  layer_done_o,
    output logic                  overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

`ifdef SQU_OUT_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Layer size
    // ------------------------------------------------------------------
    logic [10:0] kern_p1;
    logic [7:0]  dim_p1;
    logic [23:0] n_calc;
    logic [23:0] n_total;

    // N = 2^24 (largest legal layer) wraps to 0 here; the terminal compare
    // against n_total-1 then still fires on element 2^24.
    assign kern_p1 = {1'b0, no_of_squ_kernals_i} + 11'd1;
    assign dim_p1  = {1'b0, squ_layer_dimension_i} + 8'd1;
    assign n_calc  = 24'(kern_p1) * 24'(dim_p1) * 24'(dim_p1);

    // Capture the element total for the layer when it starts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_total <= 24'd1;
        end else if (start_i) begin
            n_total <= n_calc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: ReLU and requantisation
    // ------------------------------------------------------------------
    logic [7:0] q_sum;
    logic [7:0] q_next;
    logic       s1_vld;
    logic [7:0] s1_q;
    logic       unused_lsbs;

    assign unused_lsbs = ^data_i[2:0];
    assign q_sum  = {1'b0, data_i[10:4]} + {7'd0, ROUND_EN & data_i[3]};
    assign q_next = data_i[11] ? 8'd0 : (q_sum[7] ? 8'd127 : q_sum);

    // Register the requantised byte; a flag coinciding with start is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld <= 1'b0;
            s1_q   <= 8'd0;
        end else begin
            s1_vld <= flag_i & ~start_i;
            if (flag_i && !start_i) begin
                s1_q <= q_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: byte packing and element counting
    // ------------------------------------------------------------------
    logic [2:0]  lane_cnt;
    logic [23:0] elem_cnt;
    logic [63:0] pack_word;
    logic [63:0] merged_word;
    logic        last_elem;
    logic        wr_vld;
    logic        wr_last;
    logic [63:0] wr_word;

    assign last_elem = (elem_cnt == n_total - 24'd1);

    // Current partial word with the incoming byte dropped into its lane.
    always_comb begin
        merged_word = pack_word;
        merged_word[{lane_cnt, 3'b000} +: 8] = s1_q;
    end

    // Accumulate lanes; emit a word on lane 7 or on the layer's last element.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_cnt  <= 3'd0;
            elem_cnt  <= 24'd0;
            pack_word <= 64'd0;
            wr_vld    <= 1'b0;
            wr_last   <= 1'b0;
            wr_word   <= 64'd0;
        end else if (start_i) begin
            lane_cnt  <= 3'd0;
            elem_cnt  <= 24'd0;
            pack_word <= 64'd0;
            wr_vld    <= 1'b0;
            wr_last   <= 1'b0;
        end else begin
            wr_vld  <= 1'b0;
            wr_last <= 1'b0;
            if (s1_vld) begin
                if (lane_cnt == 3'd7 || last_elem) begin
                    wr_vld    <= 1'b1;
                    wr_last   <= last_elem;
                    wr_word   <= merged_word;
                    pack_word <= 64'd0;
                    lane_cnt  <= 3'd0;
                end else begin
                    pack_word <= merged_word;
                    lane_cnt  <= lane_cnt + 3'd1;
                end
                elem_cnt <= last_elem ? 24'd0 : elem_cnt + 24'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [63:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FIFO_CNT_W-1:0] count_q;
    logic [FIFO_CNT_W-1:0] count_next;
    logic                  empty_q;
    logic                  full;
    logic                  do_rd;
    logic                  do_wr;

    assign full       = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign do_rd      = fifo_out_rd_en_i & ~empty_q;
    assign do_wr      = wr_vld & (~full | do_rd);
    assign count_next = count_q + FIFO_CNT_W'(do_wr) - FIFO_CNT_W'(do_rd);

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !fifo_out_clr_i && do_wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers, count, empty flag and registered read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count_q            <= '0;
            empty_q            <= 1'b1;
            fifo_out_rd_data_o <= 64'd0;
        end else if (fifo_out_clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (do_rd) begin
                fifo_out_rd_data_o <= mem[rd_ptr];
                rd_ptr             <= rd_ptr + PTR_W'(1);
            end
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
        end
    end

    // Sticky overflow: a word arrived at a full FIFO with no read to make room.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            overflow_o <= 1'b0;
        end else if (!fifo_out_clr_i && wr_vld && full && !do_rd) begin
            overflow_o <= 1'b1;
        end
    end

    // End-of-layer pulse, aligned with the count update of the final word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            layer_done_o <= 1'b0;
        end else begin
            layer_done_o <= wr_vld & wr_last;
        end
    end

    assign fifo_out_data_count_o = count_q;
    assign fifo_out_empty_o      = empty_q;

endmodule

// File: tb/tb_squ_out_packer.sv
// Bench for squ_out_packer: directed stimulus, expected words queued by the
// stimulus process and checked by an independent monitor on every FIFO pop.

module tb_squ_out_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [9:0]  no_of_squ_kernals_i;
    logic [6:0]  squ_layer_dimension_i;
    logic [11:0] data_i;
    logic        flag_i;
    logic        fifo_out_clr_i;
    logic        fifo_out_rd_en_i;
    logic [63:0] fifo_out_rd_data_o;
    logic [6:0]  fifo_out_data_count_o;
    logic        fifo_out_empty_o;
    logic        layer_done_o;
    logic        overflow_o;

    always #5 clk_i = ~clk_i;

    squ_out_packer #(.FIFO_DEPTH(64), .FIFO_CNT_W(7)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .no_of_squ_kernals_i   (no_of_squ_kernals_i),
        .squ_layer_dimension_i (squ_layer_dimension_i),
        .data_i                (data_i),
        .flag_i                (flag_i),
        .fifo_out_clr_i        (fifo_out_clr_i),
        .fifo_out_rd_en_i      (fifo_out_rd_en_i),
        .fifo_out_rd_data_o    (fifo_out_rd_data_o),
        .fifo_out_data_count_o (fifo_out_data_count_o),
        .fifo_out_empty_o      (fifo_out_empty_o),
        .layer_done_o          (layer_done_o),
        .overflow_o            (overflow_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    int          done_cnt = 0;
    logic [6:0]  done_count_snap = '0;
    logic        rd_pend = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each popped word with the scoreboard, count done pulses.
    always @(negedge clk_i) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_word: got 0x%0h, expected no word", fifo_out_rd_data_o);
            end else begin
                check("rd_word", fifo_out_rd_data_o, exp_q.pop_front());
            end
        end
        rd_pend = fifo_out_rd_en_i && !fifo_out_empty_o && !fifo_out_clr_i && !rst_i;
        if (layer_done_o) begin
            done_cnt++;
            done_count_snap = fifo_out_data_count_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [11:0] d);
        flag_i = 1'b1;
        data_i = d;
        tick();
        flag_i = 1'b0;
    endtask

    task automatic start_layer(input logic [9:0] k, input logic [6:0] d);
        no_of_squ_kernals_i   = k;
        squ_layer_dimension_i = d;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        fifo_out_rd_en_i = 1'b1;
        while (!fifo_out_empty_o && g < 200) begin
            tick();
            g++;
        end
        fifo_out_rd_en_i = 1'b0;
        if (g >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got count %0d, expected empty", fifo_out_data_count_o);
        end
        idle(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, fifo_out_rd_data_o, 64'd0);
        check({tag, "_count"}, 64'(fifo_out_data_count_o), 64'd0);
        check({tag, "_empty"}, 64'(fifo_out_empty_o), 64'd1);
        check({tag, "_done"}, 64'(layer_done_o), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
    endtask

    initial begin
        logic [7:0] rq;
        rst_i = 1'b1;
        start_i = 1'b0;
        no_of_squ_kernals_i = '0;
        squ_layer_dimension_i = '0;
        data_i = '0;
        flag_i = 1'b0;
        fifo_out_clr_i = 1'b0;
        fifo_out_rd_en_i = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();

        // Full word, N=4, with exact latency of count and done pulse
        start_layer(10'd0, 7'd1);
        send(12'h010);
        send(12'h020);
        send(12'h030);
        exp_q.push_back(64'h0000_0000_0403_0201);
        send(12'h040);
        tick();
        check("t1_count_t2", 64'(fifo_out_data_count_o), 64'd0);
        check("t1_done_t2", 64'(layer_done_o), 64'd0);
        tick();
        check("t1_count_t3", 64'(fifo_out_data_count_o), 64'd1);
        check("t1_done_t3", 64'(layer_done_o), 64'd1);
        tick();
        check("t1_done_t4", 64'(layer_done_o), 64'd0);
        drain();
        check("t1_done_cnt", 64'(done_cnt), 64'd1);

        // ReLU / rounding, then a second layer without a new start
`ifdef SQU_OUT_ROUND_EN
        rq = 8'h02;
`else
        rq = 8'h01;
`endif
        start_layer(10'd0, 7'd1);
        send(12'h818);
        send(12'h7FF);
        send(12'h018);
        send(12'h000);
        exp_q.push_back(64'h0000_0000_0000_7F00 | (64'(rq) << 16));
        send(12'h100);
        send(12'h200);
        send(12'h300);
        send(12'h400);
        exp_q.push_back(64'h0000_0000_4030_2010);
        idle(4);
        check("t2_count", 64'(fifo_out_data_count_o), 64'd2);
        check("t2_done_cnt", 64'(done_cnt), 64'd3);
        drain();

        // N=18: two full words plus a two-byte flush
        start_layer(10'd1, 7'd2);
        for (int i = 1; i <= 18; i++) send(12'(i << 4));
        exp_q.push_back(64'h0807_0605_0403_0201);
        exp_q.push_back(64'h100F_0E0D_0C0B_0A09);
        exp_q.push_back(64'h0000_0000_0000_1211);
        idle(4);
        check("t3_count", 64'(fifo_out_data_count_o), 64'd3);
        check("t3_done_cnt", 64'(done_cnt), 64'd4);
        check("t3_done_at_count", 64'(done_count_snap), 64'd3);
        drain();

        // start mid-layer discards partial and in-flight data; flag with start ignored
        start_layer(10'd1, 7'd1);
        send(12'h0A0);
        send(12'h0B0);
        send(12'h0C0);
        flag_i = 1'b1;
        data_i = 12'h7F0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        flag_i = 1'b0;
        idle(3);
        check("t4_count_after_restart", 64'(fifo_out_data_count_o), 64'd0);
        for (int i = 0; i < 8; i++) send(12'((8'h11 + i) << 4));
        exp_q.push_back(64'h1817_1615_1413_1211);
        idle(4);
        check("t4_count", 64'(fifo_out_data_count_o), 64'd1);
        drain();

        // FIFO boundaries with N=1 (one word per element)
        start_layer(10'd0, 7'd0);
        for (int i = 0; i < 64; i++) begin
            send(12'(i << 4));
            exp_q.push_back(64'(i));
        end
        idle(3);
        check("t5_full_count", 64'(fifo_out_data_count_o), 64'd64);
        check("t5_full_ovf", 64'(overflow_o), 64'd0);
        send(12'h7F0);
        idle(3);
        check("t5_drop_ovf", 64'(overflow_o), 64'd1);
        check("t5_drop_count", 64'(fifo_out_data_count_o), 64'd64);
        start_layer(10'd0, 7'd0);
        check("t5_start_clears_ovf", 64'(overflow_o), 64'd0);
        send(12'h550);
        tick();
        fifo_out_rd_en_i = 1'b1;
        tick();
        fifo_out_rd_en_i = 1'b0;
        exp_q.push_back(64'h55);
        check("t5_wr_rd_full_count", 64'(fifo_out_data_count_o), 64'd64);
        check("t5_wr_rd_full_ovf", 64'(overflow_o), 64'd0);
        drain();
        check("t5_drained_empty", 64'(fifo_out_empty_o), 64'd1);
        fifo_out_rd_en_i = 1'b1;
        tick();
        fifo_out_rd_en_i = 1'b0;
        check("t5_rd_empty_count", 64'(fifo_out_data_count_o), 64'd0);
        check("t5_rd_empty_flag", 64'(fifo_out_empty_o), 64'd1);
        idle(2);

        // Reset with 5 words queued
        start_layer(10'd0, 7'd0);
        for (int i = 1; i <= 5; i++) send(12'(i << 4));
        idle(3);
        check("t6_queued", 64'(fifo_out_data_count_o), 64'd5);
        rst_i = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        rst_i = 1'b0;
        tick();

        // Clear coinciding with a write (N=1 after reset)
        send(12'h010);
        send(12'h020);
        send(12'h030);
        tick();
        fifo_out_clr_i = 1'b1;
        tick();
        fifo_out_clr_i = 1'b0;
        check("t6_clr_count", 64'(fifo_out_data_count_o), 64'd0);
        check("t6_clr_empty", 64'(fifo_out_empty_o), 64'd1);
        check("t6_clr_ovf", 64'(overflow_o), 64'd0);
        idle(2);
        check("t6_clr_count_later", 64'(fifo_out_data_count_o), 64'd0);
        send(12'h040);
        exp_q.push_back(64'h04);
        idle(3);
        check("t6_after_clr_count", 64'(fifo_out_data_count_o), 64'd1);
        drain();

        check("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
